// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//   Write-back stage in front of the 32x32 register bank write port.
//   Completed results (dest index + value) are queued in order and retired
//   one per cycle onto sel/data. A per-register busy scoreboard is exported
//   for upstream hazard detection.
//
// Parameters
//   DEPTH   queue entries (power of two, >= 2)
//   DATA_W  result width (matches bank data width)
//   ADDR_W  register index width
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  upstream result handshake
//   in_rd, in_data  destination index / value (in_rd = 0 is accepted and dropped)
//   wr_stall        bank write port unavailable; hold the head
//   sel, data       bank write select/data (sel = 0 means no write)
//   busy            busy[r] = a queued entry targets r (bit 0 always 0)
//   count           number of valid entries
//
// Optional feature: define WB_FWD_EN to add the decode-stage forwarding
// ports fwd_rd / fwd_hit / fwd_data (youngest matching entry, head included).
// ---------------------------------------------------------------------------
module wb_write_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_rd,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       wr_stall,
   output logic [ADDR_W-1:0]          sel,
   output logic [DATA_W-1:0]          data,
   output logic [31:0]                busy,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0]          fwd_rd,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t [DEPTH-1:0] ent;
   logic   [DEPTH-1:0] entVld;
   logic   [PTR_W-1:0] rdPtr;
   logic   [PTR_W-1:0] wrPtr;
   logic   [CNT_W-1:0] cnt;
   logic   [31:0]      busyVec;

   logic full;
   logic push;
   logic pop;

   assign full     = (cnt == CNT_W'(DEPTH));
   assign in_ready = !rst && !full;
   // Index 0 is the hardwired zero register: handshake completes, nothing stored.
   assign push     = in_valid && in_ready && (in_rd != '0);
   assign pop      = !rst && (cnt != '0) && !wr_stall;

   assign sel   = pop ? ent[rdPtr].rd   : '0;
   assign data  = pop ? ent[rdPtr].data : '0;
   assign busy  = rst ? '0 : busyVec;
   assign count = cnt;

   // Push and pop never target the same slot in one cycle: that would need
   // the queue to be both empty (pop blocked) and full (push blocked).
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr  <= '0;
         wrPtr  <= '0;
         cnt    <= '0;
         entVld <= '0;
      end else begin
         if (push) begin
            ent[wrPtr]    <= '{rd: in_rd, data: in_data};
            entVld[wrPtr] <= 1'b1;
            wrPtr         <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            entVld[rdPtr] <= 1'b0;
            rdPtr         <= rdPtr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Scoreboard covers every valid entry, including the head retiring now,
   // so a bit drops only on the edge after its last entry leaves.
   always_comb begin
      busyVec = '0;
      for (int r = 1; r < 32; r++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (entVld[e] && (ent[e].rd == ADDR_W'(r))) busyVec[r] = 1'b1;
         end
      end
   end

`ifdef WB_FWD_EN
   // Walk oldest to youngest from the head; the last match wins, which is the
   // value the bank will finally hold.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (!rst && (fwd_rd != '0)) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PTR_W'(i);
            if (entVld[idx] && (ent[idx].rd == fwd_rd)) begin
               fwd_hit  = 1'b1;
               fwd_data = ent[idx].data;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_data;
   logic              wr_stall;
   logic [ADDR_W-1:0] sel;
   logic [DATA_W-1:0] data;
   logic [31:0]       busy;
   logic [2:0]        count;
`ifdef WB_FWD_EN
   logic [ADDR_W-1:0] fwd_rd;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   int nVec = 0;
   int nErr = 0;

   wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .wr_stall(wr_stall),
      .sel(sel), .data(data), .busy(busy), .count(count)
`ifdef WB_FWD_EN
      , .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are then changed and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; wr_stall = 1'b0;
`ifdef WB_FWD_EN
      fwd_rd = '0;
`endif
      tick();
      tick();
      nVec++; if (in_ready !== 1'b0) begin nErr++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      nVec++; if (sel !== '0) begin nErr++; $display("FAIL rst_sel got=%0d exp=0", sel); end
      rst = 1'b0;
      #1;
      nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL post_rst_in_ready got=%0b exp=1", in_ready); end
      nVec++; if (sel !== '0) begin nErr++; $display("FAIL post_rst_sel got=%0d exp=0", sel); end
      nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL post_rst_count got=%0d exp=0", count); end
      nVec++; if (busy !== 32'h0) begin nErr++; $display("FAIL post_rst_busy got=%h exp=0", busy); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0;
      nVec++; if (sel !== 5'd5) begin nErr++; $display("FAIL single_sel got=%0d exp=5", sel); end
      nVec++; if (data !== 32'hDEADBEEF) begin nErr++; $display("FAIL single_data got=%h exp=deadbeef", data); end
      nVec++; if (busy !== 32'h0000_0020) begin nErr++; $display("FAIL single_busy got=%h exp=00000020", busy); end
      nVec++; if (count !== 3'd1) begin nErr++; $display("FAIL single_count got=%0d exp=1", count); end
      tick();
      nVec++; if (sel !== '0) begin nErr++; $display("FAIL single_sel_after got=%0d exp=0", sel); end
      nVec++; if (busy !== 32'h0) begin nErr++; $display("FAIL single_busy_after got=%h exp=0", busy); end
      nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL single_count_after got=%0d exp=0", count); end
   endtask

   task automatic test_stall_full();
      logic [4:0] expSel [6];
      expSel = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd0};
      wr_stall = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         in_valid = 1'b1; in_rd = 5'(r); in_data = 32'(100 + r);
         tick();
      end
      in_rd = 5'd6; in_data = 32'd106;
      nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL full_count got=%0d exp=4", count); end
      nVec++; if (in_ready !== 1'b0) begin nErr++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
      nVec++; if (busy !== 32'h0000_001E) begin nErr++; $display("FAIL full_busy got=%h exp=0000001e", busy); end
      tick();
      nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL full_hold_count got=%0d exp=4", count); end
      wr_stall = 1'b0;
      #1;
      nVec++; if (in_ready !== 1'b0) begin nErr++; $display("FAIL full_pop_in_ready got=%0b exp=0", in_ready); end
      for (int k = 0; k < 6; k++) begin
         nVec++;
         if (sel !== expSel[k]) begin nErr++; $display("FAIL drain_sel[%0d] got=%0d exp=%0d", k, sel, expSel[k]); end
         if (expSel[k] != 0) begin
            nVec++;
            if (data !== 32'(100 + expSel[k])) begin nErr++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", k, data, 100 + expSel[k]); end
         end
         if (k == 1) begin
            nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL refill_in_ready got=%0b exp=1", in_ready); end
         end
         tick();
         if (k == 1) in_valid = 1'b0;
      end
      nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL drain_count got=%0d exp=0", count); end
   endtask

   task automatic test_rd0();
      in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h1234;
      #1;
      nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL rd0_in_ready got=%0b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL rd0_count got=%0d exp=0", count); end
         nVec++; if (sel !== '0) begin nErr++; $display("FAIL rd0_sel got=%0d exp=0", sel); end
         nVec++; if (busy[0] !== 1'b0) begin nErr++; $display("FAIL rd0_busy0 got=%0b exp=0", busy[0]); end
         tick();
      end
   endtask

   task automatic test_same_rd();
      wr_stall = 1'b1;
      in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA;
      tick();
      in_data = 32'hB;
      tick();
      in_valid = 1'b0;
      nVec++; if (busy !== 32'h0000_0080) begin nErr++; $display("FAIL same_busy got=%h exp=00000080", busy); end
      nVec++; if (count !== 3'd2) begin nErr++; $display("FAIL same_count got=%0d exp=2", count); end
`ifdef WB_FWD_EN
      fwd_rd = 5'd7;
      #1;
      nVec++; if (fwd_hit !== 1'b1) begin nErr++; $display("FAIL fwd_hit got=%0b exp=1", fwd_hit); end
      nVec++; if (fwd_data !== 32'hB) begin nErr++; $display("FAIL fwd_data got=%h exp=b", fwd_data); end
      fwd_rd = 5'd0;
      #1;
      nVec++; if (fwd_hit !== 1'b0) begin nErr++; $display("FAIL fwd_rd0_hit got=%0b exp=0", fwd_hit); end
      nVec++; if (fwd_data !== '0) begin nErr++; $display("FAIL fwd_rd0_data got=%h exp=0", fwd_data); end
      fwd_rd = 5'd7;
`endif
      wr_stall = 1'b0;
      #1;
      nVec++; if (sel !== 5'd7 || data !== 32'hA) begin nErr++; $display("FAIL same_first got=%0d/%h exp=7/a", sel, data); end
`ifdef WB_FWD_EN
      nVec++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin nErr++; $display("FAIL fwd_retire got=%0b/%h exp=1/b", fwd_hit, fwd_data); end
`endif
      tick();
      nVec++; if (sel !== 5'd7 || data !== 32'hB) begin nErr++; $display("FAIL same_second got=%0d/%h exp=7/b", sel, data); end
      nVec++; if (busy !== 32'h0000_0080) begin nErr++; $display("FAIL same_busy_head got=%h exp=00000080", busy); end
`ifdef WB_FWD_EN
      nVec++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin nErr++; $display("FAIL fwd_last got=%0b/%h exp=1/b", fwd_hit, fwd_data); end
`endif
      tick();
      nVec++; if (sel !== '0 || busy !== 32'h0) begin nErr++; $display("FAIL same_done got=%0d/%h exp=0/0", sel, busy); end
`ifdef WB_FWD_EN
      nVec++; if (fwd_hit !== 1'b0) begin nErr++; $display("FAIL fwd_empty got=%0b exp=0", fwd_hit); end
      fwd_rd = 5'd0;
`endif
   endtask

   task automatic test_back_to_back();
      // Six pushes through a 4-deep queue exercise pointer wrap with push+pop each edge.
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_rd = 5'(k + 1); in_data = 32'(k * 16 + 3);
         tick();
         nVec++;
         if (sel !== 5'(k + 1) || data !== 32'(k * 16 + 3) || count !== 3'd1) begin
            nErr++;
            $display("FAIL b2b[%0d] got sel=%0d data=%0d cnt=%0d exp sel=%0d data=%0d cnt=1",
                     k, sel, data, count, k + 1, k * 16 + 3);
         end
      end
      in_valid = 1'b0;
      tick();
      nVec++; if (count !== 3'd0 || sel !== '0) begin nErr++; $display("FAIL b2b_end got cnt=%0d sel=%0d exp 0/0", count, sel); end
   endtask

   task automatic test_reset_mid();
      wr_stall = 1'b1;
      for (int r = 9; r <= 11; r++) begin
         in_valid = 1'b1; in_rd = 5'(r); in_data = 32'(r);
         tick();
      end
      in_valid = 1'b0;
      nVec++; if (count !== 3'd3) begin nErr++; $display("FAIL mid_count_pre got=%0d exp=3", count); end
      rst = 1'b1; wr_stall = 1'b0;
      #1;
      nVec++; if (sel !== '0 || busy !== 32'h0 || in_ready !== 1'b0) begin
         nErr++; $display("FAIL mid_in_rst got sel=%0d busy=%h rdy=%0b exp 0/0/0", sel, busy, in_ready); end
      tick();
      rst = 1'b0;
      #1;
      nVec++; if (count !== 3'd0 || busy !== 32'h0) begin nErr++; $display("FAIL mid_after got cnt=%0d busy=%h exp 0/0", count, busy); end
      for (int k = 0; k < 4; k++) begin
         nVec++; if (sel !== '0) begin nErr++; $display("FAIL mid_no_write[%0d] got=%0d exp=0", k, sel); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall_full();
      test_rd0();
      test_same_rd();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
